// File: rtl/eth_sync_fifo_pkg.sv
// Shared constants and helpers for the Ethernet MAC word buffer.
// Latency: none (package only).
// Backpressure: n/a.
package eth_sync_fifo_pkg;

    localparam int ETH_FIFO_DEPTH_DEF = 8;
    localparam int ETH_WIDTH_DEF      = 16;

    // Ceiling log2 usable in parameter expressions; returns 0 for value <= 1.
    function automatic int eth_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_fifo_ctrl.sv
// Pointer, occupancy, flag and watermark control for eth_sync_fifo.
// Latency: all flags registered; a push at edge N is counted after edge N.
// Backpressure: in_rdy drops when full or during flush; a same-cycle pop never frees a slot.
module eth_fifo_ctrl
    import eth_sync_fifo_pkg::*;
#(
    parameter int DEPTH    = ETH_FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = ETH_FIFO_DEPTH_DEF - 2,
    parameter int AW       = eth_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          flush,
    input  logic          in_val,
    input  logic          out_rdy,
    output logic          in_rdy,
    output logic          out_val,
    output logic [AW:0]   count,
    output logic          almost_full,
    output logic          ovf,
    output logic [AW:0]   peak,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_next;
    logic [AW:0]   peak_q;
    logic          af_q;
    logic          ovf_q;
    logic          push;
    logic          pop;

    // Handshakes: full blocks writes regardless of a concurrent pop.
    assign in_rdy  = (count_q != CNT_FULL) & ~flush;
    assign out_val = (count_q != '0);
    assign push    = in_val & in_rdy;
    assign pop     = out_val & out_rdy;

    assign count       = count_q;
    assign almost_full = af_q;
    assign ovf         = ovf_q;
    assign peak        = peak_q;
    assign wr_en       = push;
    assign wr_addr     = wr_ptr;
    assign rd_addr     = rd_ptr;

    // Next occupancy: flush wins, push and pop together hold the count.
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_q - CNT_ONE;
        end
    end

    // State update: pointers roll over naturally, flags track count_next.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            peak_q  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                peak_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (in_val && !in_rdy) ovf_q <= 1'b1;
                if (count_next > peak_q) peak_q <= count_next;
            end
            count_q <= count_next;
            af_q    <= (count_next >= CNT_AF);
        end
    end

endmodule

// File: rtl/eth_sync_fifo.sv
// DEPTH-entry first-word-fall-through buffer between MAC byte engines and host words.
// Latency: word pushed at edge N is presented on out_data after edge N (no bypass).
// Backpressure: in_rdy low when full or flushing; out_val low when empty.
module eth_sync_fifo
    import eth_sync_fifo_pkg::*;
#(
    parameter  int WIDTH    = ETH_WIDTH_DEF,
    parameter  int DEPTH    = ETH_FIFO_DEPTH_DEF,
    parameter  int AF_LEVEL = DEPTH - 2,
    localparam int AW       = eth_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             flush,
    input  logic             in_val,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_rdy,
    output logic             out_val,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rdy,
    output logic [AW:0]      count,
    output logic             almost_full,
    output logic             ovf,
    output logic [AW:0]      peak
);

    // Reject configurations the pointer arithmetic cannot support.
    if (WIDTH < 1) begin : g_bad_width
        $error("eth_sync_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("eth_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("eth_sync_fifo: AF_LEVEL must be in 1..DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    eth_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AW       (AW)
    ) u_ctrl (
        .clk         (clk),
        .res         (res),
        .flush       (flush),
        .in_val      (in_val),
        .out_rdy     (out_rdy),
        .in_rdy      (in_rdy),
        .out_val     (out_val),
        .count       (count),
        .almost_full (almost_full),
        .ovf         (ovf),
        .peak        (peak),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr)
    );

    // Storage: cleared on reset so out_data reads zero, kept across flush.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    assign out_data = mem[rd_addr];

endmodule

// File: tb/tb_eth_sync_fifo.sv
module tb_eth_sync_fifo;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AF = 6;

    logic        clk = 1'b0;
    logic        res;
    logic        flush;
    logic        in_val;
    logic [15:0] in_data;
    logic        in_rdy;
    logic        out_val;
    logic [15:0] out_data;
    logic        out_rdy;
    logic [3:0]  count;
    logic        almost_full;
    logic        ovf;
    logic [3:0]  peak;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of stored words plus sticky flags.
    logic [15:0] mq[$];
    bit          movf;
    int          mpeak;

    typedef struct {
        bit          f;
        bit          iv;
        logic [15:0] d;
        bit          ordy;
        int          e_count;
        bit          e_val;
        int          e_data;
        bit          e_rdy;
        bit          e_af;
        bit          e_ovf;
        int          e_peak;
    } vec_t;

    vec_t tbl[17];

    always #5 clk = ~clk;

    eth_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .res         (res),
        .flush       (flush),
        .in_val      (in_val),
        .in_data     (in_data),
        .in_rdy      (in_rdy),
        .out_val     (out_val),
        .out_data    (out_data),
        .out_rdy     (out_rdy),
        .count       (count),
        .almost_full (almost_full),
        .ovf         (ovf),
        .peak        (peak)
    );

    task automatic cmp(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit f, input bit iv, input logic [15:0] d, input bit ordy);
        int  n;
        bit  push;
        bit  pop;
        if (f) begin
            mq.delete();
            movf  = 1'b0;
            mpeak = 0;
        end else begin
            n    = mq.size();
            push = iv && (n < D);
            pop  = (n > 0) && ordy;
            if (iv && !push) movf = 1'b1;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
            if (mq.size() > mpeak) mpeak = mq.size();
        end
    endtask

    task automatic check_state();
        cmp("count", 32'(count), mq.size());
        cmp("out_val", 32'(out_val), (mq.size() > 0) ? 1 : 0);
        if (mq.size() > 0) cmp("out_data", 32'(out_data), int'(mq[0]));
        cmp("almost_full", 32'(almost_full), (mq.size() >= AF) ? 1 : 0);
        cmp("ovf", 32'(ovf), int'(movf));
        cmp("peak", 32'(peak), mpeak);
    endtask

    task automatic drive_cycle(input bit f, input bit iv, input logic [15:0] d, input bit ordy);
        @(negedge clk);
        flush   = f;
        in_val  = iv;
        in_data = d;
        out_rdy = ordy;
        #1;
        cmp("in_rdy", 32'(in_rdy), ((mq.size() != D) && !f) ? 1 : 0);
        @(posedge clk);
        model_edge(f, iv, d, ordy);
        #1;
        check_state();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        flush = 1'b0;
        #2;
        res = 1'b1;
        #1;
        cmp("rst_count", 32'(count), 0);
        cmp("rst_out_val", 32'(out_val), 0);
        cmp("rst_out_data", 32'(out_data), 0);
        cmp("rst_in_rdy", 32'(in_rdy), 1);
        cmp("rst_af", 32'(almost_full), 0);
        cmp("rst_ovf", 32'(ovf), 0);
        cmp("rst_peak", 32'(peak), 0);
        mq.delete();
        movf  = 1'b0;
        mpeak = 0;
        @(negedge clk);
        in_val  = 1'b0;
        out_rdy = 1'b0;
        res     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        int          phase_rdy;
        int          phase_val;

        res     = 1'b1;
        flush   = 1'b0;
        in_val  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;

        // Fill 8, overflow with a 9th, then drain 8 in order.
        for (int k = 1; k <= 8; k++)
            tbl[k-1] = '{1'b0, 1'b1, 16'(k), 1'b0, k, 1'b1, 1, (k < 8), (k >= AF), 1'b0, k};
        tbl[8] = '{1'b0, 1'b1, 16'h0009, 1'b0, 8, 1'b1, 1, 1'b0, 1'b1, 1'b1, 8};
        for (int j = 1; j <= 8; j++)
            tbl[8+j] = '{1'b0, 1'b0, 16'h0000, 1'b1, 8 - j, (j < 8), j + 1, 1'b1, ((8 - j) >= AF), 1'b1, 8};

        do_reset();

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            flush   = tbl[i].f;
            in_val  = tbl[i].iv;
            in_data = tbl[i].d;
            out_rdy = tbl[i].ordy;
            @(posedge clk);
            #1;
            cmp("tbl_count", 32'(count), tbl[i].e_count);
            cmp("tbl_out_val", 32'(out_val), int'(tbl[i].e_val));
            if (tbl[i].e_val) cmp("tbl_out_data", 32'(out_data), tbl[i].e_data);
            cmp("tbl_in_rdy", 32'(in_rdy), int'(tbl[i].e_rdy));
            cmp("tbl_af", 32'(almost_full), int'(tbl[i].e_af));
            cmp("tbl_ovf", 32'(ovf), int'(tbl[i].e_ovf));
            cmp("tbl_peak", 32'(peak), tbl[i].e_peak);
        end

        // Reset mid-stream with five words stored and in_val still high.
        do_reset();
        for (int k = 0; k < 5; k++) drive_cycle(1'b0, 1'b1, 16'h0100 + 16'(k), 1'b0);
        do_reset();

        // Pointer wrap under continuous push and pop.
        seq = 16'h0200;
        for (int k = 0; k < 3; k++) begin drive_cycle(1'b0, 1'b1, seq, 1'b0); seq++; end
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        drive_cycle(1'b0, 1'b1, seq, 1'b0);
        seq++;
        for (int k = 0; k < 20; k++) begin drive_cycle(1'b0, 1'b1, seq, 1'b1); seq++; end
        cmp("wrap_count", 32'(count), 1);
        cmp("wrap_ovf", 32'(ovf), 0);

        // Full with concurrent pop: only the pop happens, push lands next cycle.
        do_reset();
        for (int k = 0; k < 8; k++) drive_cycle(1'b0, 1'b1, 16'h0300 + 16'(k), 1'b0);
        drive_cycle(1'b0, 1'b1, 16'h03AA, 1'b1);
        cmp("full_pop_count", 32'(count), 7);
        drive_cycle(1'b0, 1'b1, 16'h03BB, 1'b0);
        cmp("full_push_next", 32'(count), 8);

        // Flush with traffic: contents, ovf and peak cleared.
        do_reset();
        for (int k = 0; k < 9; k++) drive_cycle(1'b0, 1'b1, 16'h0400 + 16'(k), 1'b0);
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        drive_cycle(1'b1, 1'b1, 16'h04EE, 1'b1);
        cmp("flush_count", 32'(count), 0);
        cmp("flush_ovf", 32'(ovf), 0);
        cmp("flush_peak", 32'(peak), 0);
        drive_cycle(1'b0, 1'b1, 16'hABCD, 1'b0);
        cmp("flush_next_data", 32'(out_data), 32'h0000ABCD);

        // Randomised traffic with phases biased toward full and empty.
        do_reset();
        phase_rdy = 50;
        phase_val = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                phase_rdy = $urandom_range(10, 90);
                phase_val = $urandom_range(10, 90);
            end
            drive_cycle(($urandom_range(0, 63) == 0),
                        ($urandom_range(0, 99) < phase_val),
                        16'($urandom),
                        ($urandom_range(0, 99) < phase_rdy));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
